// File: rtl/seq_onehot_decoder_pkg.sv
// seq_decoder_pkg
// Shared types and helpers for the registered one-hot line decoder.
//   state_e      : controller state (IDLE, HOLD)
//   MODE_DIRECT  : hold a single line for dwell+1 cycles
//   MODE_SCAN    : walk upward from the start line to the top line
//   onehot(idx)  : 1 << idx over the widest supported output; callers
//                  size-cast the result down to their own line count
// No ports (package).
package seq_decoder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Widest select the helper supports (256 lines).
  localparam int unsigned SEL_W_MAX   = 8;
  localparam int unsigned ONEHOT_W_MAX = 1 << SEL_W_MAX;

  function automatic logic [ONEHOT_W_MAX-1:0] onehot(input logic [SEL_W_MAX-1:0] idx);
    logic [ONEHOT_W_MAX-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/seq_onehot_decoder_if.sv
// seq_onehot_decoder_if
// Command channel into the decoder (valid/ready handshake).
//   in_valid  : command present (master -> slave)
//   in_ready  : decoder can accept a command (slave -> master)
//   in_sel    : start/target line index
//   in_mode   : 0 = direct, 1 = scan
//   in_dwell  : hold cycles minus one per line
// Modports: master (command source), slave (decoder).
interface seq_onehot_decoder_if #(
  parameter int SEL_W   = 2,
  parameter int DWELL_W = 4
);

  logic               in_valid;
  logic               in_ready;
  logic [SEL_W-1:0]   in_sel;
  logic               in_mode;
  logic [DWELL_W-1:0] in_dwell;

  modport master (
    output in_valid,
    output in_sel,
    output in_mode,
    output in_dwell,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_sel,
    input  in_mode,
    input  in_dwell,
    output in_ready
  );

endinterface

// File: rtl/seq_onehot_decoder_dwell_counter.sv
// dwell_counter
// Loadable down-counter that times how long each line stays asserted.
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset (count clears to 0)
//   i_load     : load i_load_val this cycle (wins over i_dec)
//   i_load_val : value to load
//   i_dec      : decrement by one; saturates at zero
//   o_zero     : count is zero (terminal count)
module dwell_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/seq_onehot_decoder.sv
// seq_onehot_decoder
// Registered SEL_W -> 2**SEL_W line decoder with direct and scan modes.
// Direct holds line `sel` for dwell+1 cycles; scan walks from `sel` up to
// the top line, dwell+1 cycles per line, with no gap or overlap.
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   cmd        : command channel (slave modport: in_valid/in_ready/in_sel/
//                in_mode/in_dwell)
//   abort      : synchronous cancel of the active command; also blocks
//                acceptance while idle
//   out_onehot : registered line enables
//   busy       : command in progress
//   done       : one-cycle pulse on normal completion (not on abort)
// Build option SEQ_DECODER_ACTIVE_LOW_EN: when defined, out_onehot is
// driven one-cold (idle all ones, active line low). Only the output
// register is affected; all other state and timing are identical.
//
// state | meaning
// IDLE  | no command; in_ready high unless abort; outputs idle
// HOLD  | a line is asserted; dwell counter times the current line
module seq_onehot_decoder
  import seq_decoder_pkg::*;
#(
  parameter int SEL_W   = 2,
  parameter int DWELL_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seq_onehot_decoder_if.slave   cmd,
  input  logic                  abort,
  output logic [(2**SEL_W)-1:0] out_onehot,
  output logic                  busy,
  output logic                  done
);

  localparam int N = 2 ** SEL_W;

  state_e             r_state;
  state_e             w_state_nxt;
  logic [SEL_W-1:0]   r_idx;
  logic [SEL_W-1:0]   w_idx_nxt;
  logic               r_mode;
  logic [DWELL_W-1:0] r_dwell;
  logic               r_done;
  logic               w_done_nxt;
  logic [N-1:0]       r_out;
  logic [N-1:0]       w_line_at_idx;
  logic [N-1:0]       w_line_nxt;
  logic               w_accept;
  logic               w_last;
  logic               w_latch;
  logic               w_cnt_load;
  logic               w_cnt_dec;
  logic [DWELL_W-1:0] w_cnt_val;
  logic               w_cnt_zero;

  assign cmd.in_ready = (r_state == IDLE) && !abort;
  assign w_accept     = cmd.in_valid && cmd.in_ready;

  // The top line has an all-ones index; scan ends there like direct does.
  assign w_last = (r_mode == MODE_DIRECT) || (&r_idx);

  dwell_counter #(
    .W (DWELL_W)
  ) u_dwell_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_val),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; abort takes priority over a completing line.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (abort) begin
          w_state_nxt = IDLE;
        end else if (w_cnt_zero && w_last) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output / datapath control
  always_comb begin
    w_idx_nxt  = r_idx;
    w_done_nxt = 1'b0;
    w_latch    = 1'b0;
    w_cnt_load = 1'b0;
    w_cnt_dec  = 1'b0;
    w_cnt_val  = r_dwell;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_latch    = 1'b1;
          w_idx_nxt  = cmd.in_sel;
          w_cnt_load = 1'b1;
          w_cnt_val  = cmd.in_dwell;
        end
      end
      HOLD: begin
        if (abort) begin
          w_cnt_load = 1'b1;
          w_cnt_val  = '0;
        end else if (w_cnt_zero) begin
          if (w_last) begin
            w_done_nxt = 1'b1;
          end else begin
            w_idx_nxt  = r_idx + SEL_W'(1);
            w_cnt_load = 1'b1;
          end
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Line enables are a pure function of next state and index, so at most
  // one line can ever be set.
  assign w_line_at_idx = N'(onehot(SEL_W_MAX'(w_idx_nxt)));
  assign w_line_nxt    = (w_state_nxt == HOLD) ? w_line_at_idx : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_mode  <= MODE_DIRECT;
      r_dwell <= '0;
      r_done  <= 1'b0;
`ifdef SEQ_DECODER_ACTIVE_LOW_EN
      r_out   <= '1;
`else
      r_out   <= '0;
`endif
    end else begin
      r_idx  <= w_idx_nxt;
      r_done <= w_done_nxt;
      if (w_latch) begin
        r_mode  <= cmd.in_mode;
        r_dwell <= cmd.in_dwell;
      end
`ifdef SEQ_DECODER_ACTIVE_LOW_EN
      r_out <= ~w_line_nxt;
`else
      r_out <= w_line_nxt;
`endif
    end
  end

  assign out_onehot = r_out;
  assign busy       = (r_state == HOLD);
  assign done       = r_done;

endmodule

// File: tb/tb_seq_onehot_decoder.sv
module tb_seq_onehot_decoder;

  localparam int SEL_W   = 2;
  localparam int DWELL_W = 4;
  localparam int N       = 4;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         abort = 1'b0;
  logic [N-1:0] out_onehot;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_pass   = 0;

  seq_onehot_decoder_if #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) bus ();

  seq_onehot_decoder #(
    .SEL_W   (SEL_W),
    .DWELL_W (DWELL_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd        (bus.slave),
    .abort      (abort),
    .out_onehot (out_onehot),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Expected pin values for a given set of active lines.
  function automatic logic [N-1:0] pins(input int lines);
`ifdef SEQ_DECODER_ACTIVE_LOW_EN
    return ~N'(lines);
`else
    return N'(lines);
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic idle_checks(input string tag);
    chk({tag, "_out"},  32'(out_onehot), 32'(pins(0)));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Called at a negedge; returns at the negedge of the first HOLD cycle.
  task automatic issue(input int sel, input int mode, input int dwell);
    bus.in_valid = 1'b1;
    bus.in_sel   = SEL_W'(sel);
    bus.in_mode  = mode[0];
    bus.in_dwell = DWELL_W'(dwell);
    #1 chk("ready_at_accept", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Reference trace: each line from sel up to the last line held dwell+1
  // cycles. abort_at/stop_at are 1-based HOLD cycle numbers (0 = never).
  // Normal completion returns at the negedge of the done cycle.
  task automatic follow(input int sel, input int mode, input int dwell,
                        input int abort_at, input int stop_at);
    int q[$];
    int last;
    last = (mode != 0) ? N - 1 : sel;
    for (int i = sel; i <= last; i++)
      for (int r = 0; r <= dwell; r++)
        q.push_back(1 << i);
    for (int k = 0; k < q.size(); k++) begin
      chk("line",       32'(out_onehot),   32'(pins(q[k])));
      chk("busy_hold",  32'(busy),         32'd1);
      chk("done_hold",  32'(done),         32'd0);
      chk("ready_hold", 32'(bus.in_ready), 32'd0);
      if (k + 1 == stop_at) return;
      if (k + 1 == abort_at) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1;
        idle_checks("abort");
        chk("abort_done",  32'(done),         32'd0);
        chk("abort_ready", 32'(bus.in_ready), 32'd1);
        return;
      end
      // Command inputs must be ignored while a command is active.
      bus.in_sel   = SEL_W'($urandom);
      bus.in_mode  = 1'($urandom);
      bus.in_dwell = DWELL_W'($urandom);
      @(negedge clk);
    end
    idle_checks("end");
    chk("done_pulse", 32'(done),         32'd1);
    chk("done_ready", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    idle_checks("idle");
    chk("idle_done", 32'(done), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    int sel, mode, dwell, len, ab;
    bus.in_valid = 1'b0;
    bus.in_sel   = '0;
    bus.in_mode  = 1'b0;
    bus.in_dwell = '0;

    // Reset state
    #2;
    idle_checks("reset");
    chk("reset_done",  32'(done),         32'd0);
    chk("reset_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycle();

    // Direct sel=2 dwell=3
    issue(2, 0, 3); follow(2, 0, 3, 0, 0); idle_cycle();

    // Scan sel=1 dwell=0
    issue(1, 1, 0); follow(1, 1, 0, 0, 0); idle_cycle();

    // Scan sel=0 dwell=2, abort on 5th HOLD cycle
    issue(0, 1, 2); follow(0, 1, 2, 5, 0); idle_cycle();

    // Abort while idle blocks acceptance
    bus.in_valid = 1'b1;
    bus.in_sel   = 2'd3;
    abort        = 1'b1;
    #1 chk("idle_abort_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    abort = 1'b0;
    idle_checks("idle_abort");
    issue(3, 0, 1); follow(3, 0, 1, 0, 0);

    // Back-to-back: second command presented in the done cycle
    issue(3, 0, 0); follow(3, 0, 0, 0, 0);
    issue(0, 0, 0); follow(0, 0, 0, 0, 0); idle_cycle();

    // Scan from the top line behaves like direct
    issue(3, 1, 2); follow(3, 1, 2, 0, 0); idle_cycle();

    // Reset mid-scan while line 2 is active
    issue(0, 1, 1); follow(0, 1, 1, 0, 5);
    rst_n = 1'b0;
    #1;
    idle_checks("async_reset");
    chk("async_reset_done",  32'(done),         32'd0);
    chk("async_reset_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycle();
    issue(1, 0, 3); follow(1, 0, 3, 0, 0); idle_cycle();

    // Randomized commands against the reference trace
    for (int it = 0; it < 24; it++) begin
      sel   = int'($urandom_range(0, N - 1));
      mode  = int'($urandom_range(0, 1));
      dwell = int'($urandom_range(0, 3));
      len   = ((mode != 0) ? (N - sel) : 1) * (dwell + 1);
      ab    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, len)) : 0;
      issue(sel, mode, dwell);
      follow(sel, mode, dwell, ab, 0);
      if (ab != 0 || $urandom_range(0, 1) == 0) idle_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
